// File: rtl/pipeline_stall_ctrl_if.sv
// pipeline_stall_ctrl_if: hazard/cache status from the pipeline and the stall/flush controls back to it
interface pipeline_stall_ctrl_if #(parameter int CNT_W = 16);
    logic [3:0]       ID_RegRd1, ID_RegRd2, ID_EX_RegWd;
    logic             ID_UsesRd1, ID_UsesRd2, ID_IsStore;
    logic             ID_EX_MemRead, ID_EX_RegWrite, EX_BranchTaken;
    logic             ic_miss, ic_ready, dc_miss, dc_ready;
    logic             pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush;
    logic             EX_MEM_stall, MEM_WB_flush;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    modport master (
        output ID_RegRd1, ID_RegRd2, ID_EX_RegWd, ID_UsesRd1, ID_UsesRd2, ID_IsStore,
               ID_EX_MemRead, ID_EX_RegWrite, EX_BranchTaken,
               ic_miss, ic_ready, dc_miss, dc_ready,
        input  pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
               EX_MEM_stall, MEM_WB_flush, stall_cycles, flush_count
    );

    modport slave (
        input  ID_RegRd1, ID_RegRd2, ID_EX_RegWd, ID_UsesRd1, ID_UsesRd2, ID_IsStore,
               ID_EX_MemRead, ID_EX_RegWrite, EX_BranchTaken,
               ic_miss, ic_ready, dc_miss, dc_ready,
        output pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
               EX_MEM_stall, MEM_WB_flush, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: load-use, cache-miss and taken-branch stall/flush sequencer with saturating perf counters
module pipeline_stall_ctrl #(parameter int CNT_W = 16) (
    input logic clk,
    input logic rst_n,
    pipeline_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, DWAIT, IWAIT} state_t;
    state_t state, state_nx;
    logic squash_pend, squash_nx;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic load_use, br, kill, dstall, istall, count_flush;

    always_comb begin
        load_use = bus.ID_EX_MemRead & bus.ID_EX_RegWrite & (bus.ID_EX_RegWd != 4'd0) &
                   ((bus.ID_UsesRd1 & (bus.ID_RegRd1 == bus.ID_EX_RegWd)) |
                    (bus.ID_UsesRd2 & (bus.ID_RegRd2 == bus.ID_EX_RegWd) & ~bus.ID_IsStore));
        br = bus.EX_BranchTaken;
        kill = br | squash_pend;
        // a D-miss freezes everything; the ready cycle of either wait behaves like a RUN cycle
        dstall = (state == DWAIT) ? ~bus.dc_ready : bus.dc_miss;
        istall = ~dstall & ((state == IWAIT) ? ~bus.ic_ready : bus.ic_miss);
        bus.pc_stall = 1'b0;
        bus.IF_ID_stall = 1'b0;
        bus.IF_ID_flush = 1'b0;
        bus.ID_EX_stall = 1'b0;
        bus.ID_EX_flush = 1'b0;
        bus.EX_MEM_stall = 1'b0;
        bus.MEM_WB_flush = 1'b0;
        state_nx = RUN;
        squash_nx = 1'b0;
        count_flush = 1'b0;
        if (!rst_n) begin
            bus.IF_ID_flush = 1'b1;
            bus.ID_EX_flush = 1'b1;
        end else if (dstall) begin
            bus.pc_stall = 1'b1;
            bus.IF_ID_stall = 1'b1;
            bus.ID_EX_stall = 1'b1;
            bus.EX_MEM_stall = 1'b1;
            bus.MEM_WB_flush = 1'b1;
            state_nx = DWAIT;
            squash_nx = squash_pend;
        end else if (istall) begin
            // a taken branch lets the PC load its target while the stale fetch is squashed later
            bus.pc_stall = ~br;
            bus.IF_ID_stall = 1'b1;
            bus.ID_EX_flush = 1'b1;
            state_nx = IWAIT;
            squash_nx = squash_pend | br;
            count_flush = br;
        end else begin
            bus.IF_ID_flush = kill;
            bus.ID_EX_flush = kill | load_use;
            bus.pc_stall = load_use & ~kill;
            bus.IF_ID_stall = load_use & ~kill;
            count_flush = br;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            squash_pend <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nx;
            squash_pend <= squash_nx;
            if (bus.pc_stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (count_flush && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign bus.stall_cycles = rst_n ? stall_cnt : '0;
    assign bus.flush_count = rst_n ? flush_cnt : '0;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed + random stimulus, reference model feeds a scoreboard checked by a monitor
module tb_pipeline_stall_ctrl;
    localparam int CW = 6;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipeline_stall_ctrl_if #(.CNT_W(CW)) bus();
    pipeline_stall_ctrl #(.CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic       rst;
        logic [3:0] r1, r2, wd;
        logic       u1, u2, st, mr, rw, br, icm, icr, dcm, dcr;
    } stim_t;

    // ctl = {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall, MEM_WB_flush}
    typedef struct packed {
        logic [6:0]    ctl;
        logic [CW-1:0] sc, fc;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0;

    // model: outstanding data fill, outstanding instruction fill, wrong-path fetch awaiting a kill
    bit d_fill, i_fill, wrong_path;
    int n_stall, n_flush;

    task automatic apply(input stim_t s);
        exp_t e;
        bit hazard, mem_frozen, fetch_frozen, kill, flushed;
        @(posedge clk);
        #1;
        rst_n = ~s.rst;
        bus.ID_RegRd1 = s.r1;
        bus.ID_RegRd2 = s.r2;
        bus.ID_EX_RegWd = s.wd;
        bus.ID_UsesRd1 = s.u1;
        bus.ID_UsesRd2 = s.u2;
        bus.ID_IsStore = s.st;
        bus.ID_EX_MemRead = s.mr;
        bus.ID_EX_RegWrite = s.rw;
        bus.EX_BranchTaken = s.br;
        bus.ic_miss = s.icm;
        bus.ic_ready = s.icr;
        bus.dc_miss = s.dcm;
        bus.dc_ready = s.dcr;
        if (s.rst) begin
            e.ctl = 7'b0010100;
            e.sc = '0;
            e.fc = '0;
            q.push_back(e);
            d_fill = 0; i_fill = 0; wrong_path = 0; n_stall = 0; n_flush = 0;
            return;
        end
        hazard = s.mr && s.rw && s.wd != 4'd0 &&
                 ((s.u1 && s.r1 == s.wd) || (s.u2 && s.r2 == s.wd && !s.st));
        mem_frozen = d_fill ? !s.dcr : s.dcm;
        fetch_frozen = i_fill ? !s.icr : s.icm;
        flushed = 0;
        if (mem_frozen) begin
            e.ctl = 7'b1101011;
            d_fill = 1;
            i_fill = 0;
        end else if (fetch_frozen) begin
            e.ctl = {!s.br, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00};
            d_fill = 0;
            i_fill = 1;
            wrong_path = wrong_path || s.br;
            flushed = s.br;
        end else begin
            kill = s.br || wrong_path;
            e.ctl = {hazard && !kill, hazard && !kill, kill, 1'b0, kill || hazard, 2'b00};
            d_fill = 0;
            i_fill = 0;
            wrong_path = 0;
            flushed = s.br;
        end
        e.sc = CW'(n_stall);
        e.fc = CW'(n_flush);
        q.push_back(e);
        if (e.ctl[6] && n_stall < MAXC) n_stall++;
        if (flushed && n_flush < MAXC) n_flush++;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        logic [6:0] got;
        if (q.size() > 0) begin
            e = q.pop_front();
            got = {bus.pc_stall, bus.IF_ID_stall, bus.IF_ID_flush, bus.ID_EX_stall,
                   bus.ID_EX_flush, bus.EX_MEM_stall, bus.MEM_WB_flush};
            checks++;
            if (got !== e.ctl) begin
                errors++;
                $display("FAIL ctl @%0t got %b want %b", $time, got, e.ctl);
            end
            checks++;
            if (bus.stall_cycles !== e.sc) begin
                errors++;
                $display("FAIL stall_cycles @%0t got %0d want %0d", $time, bus.stall_cycles, e.sc);
            end
            checks++;
            if (bus.flush_count !== e.fc) begin
                errors++;
                $display("FAIL flush_count @%0t got %0d want %0d", $time, bus.flush_count, e.fc);
            end
        end
    end

    initial begin
        stim_t s;
        rst_n = 1'b0;
        s = '0;
        {bus.ID_RegRd1, bus.ID_RegRd2, bus.ID_EX_RegWd} = '0;
        {bus.ID_UsesRd1, bus.ID_UsesRd2, bus.ID_IsStore, bus.ID_EX_MemRead, bus.ID_EX_RegWrite} = '0;
        {bus.EX_BranchTaken, bus.ic_miss, bus.ic_ready, bus.dc_miss, bus.dc_ready} = '0;
        s.rst = 1; apply(s); apply(s);
        s = '0; apply(s);
        // load-use on Rd1, then the same pattern on R0
        s.mr = 1; s.rw = 1; s.wd = 4'd3; s.u1 = 1; s.r1 = 4'd3; apply(s);
        s = '0; apply(s);
        s.mr = 1; s.rw = 1; s.wd = 4'd0; s.u1 = 1; s.r1 = 4'd0; apply(s);
        // store data on Rd2 never stalls; store base on Rd1 does
        s = '0; s.mr = 1; s.rw = 1; s.wd = 4'd3; s.u2 = 1; s.r2 = 4'd3; s.st = 1; apply(s);
        s.u1 = 1; s.r1 = 4'd3; s.u2 = 0; apply(s);
        // branch overrides load-use
        s.br = 1; apply(s);
        // D-miss, ready after 6 cycles
        s = '0; s.dcm = 1; apply(s);
        s.dcm = 0; repeat (5) apply(s);
        s.dcr = 1; apply(s);
        s = '0; apply(s);
        // simultaneous I- and D-miss
        s.icm = 1; s.dcm = 1; apply(s);
        s.dcm = 0; repeat (3) apply(s);
        s.dcr = 1; apply(s);
        s.dcr = 0; repeat (3) apply(s);
        s.icm = 0; s.icr = 1; apply(s);
        s = '0; apply(s);
        // I-miss with a taken branch in the second wait cycle
        s.icm = 1; apply(s);
        s.icm = 0; apply(s);
        s.br = 1; apply(s);
        s.br = 0; apply(s);
        s.icr = 1; apply(s);
        s = '0; apply(s);
        // reset in the middle of a D-miss
        s.dcm = 1; apply(s);
        s.dcm = 0; repeat (2) apply(s);
        s.rst = 1; apply(s);
        s.rst = 0; repeat (2) apply(s);
        // long D-miss saturates the stall counter
        s.dcm = 1; apply(s);
        s.dcm = 0; repeat (70) apply(s);
        s.dcr = 1; apply(s);
        repeat (3000) begin
            s.rst = ($urandom_range(119) == 0);
            s.r1 = 4'($urandom_range(3));
            s.r2 = 4'($urandom_range(3));
            s.wd = 4'($urandom_range(3));
            s.u1 = 1'($urandom);
            s.u2 = 1'($urandom);
            s.st = 1'($urandom);
            s.mr = 1'($urandom);
            s.rw = 1'($urandom);
            s.br = ($urandom_range(5) == 0);
            s.icm = ($urandom_range(7) == 0);
            s.icr = ($urandom_range(3) == 0);
            s.dcm = ($urandom_range(9) == 0);
            s.dcr = ($urandom_range(3) == 0);
            apply(s);
        end
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
